// File: rtl/uart_pkg.sv
// Shared definitions for the UART framing layer: sync marker, error codes
// and the frame parser state encoding.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } parser_state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one synchronous write port, one asynchronous read
// port. Addresses outside the array write nothing and read zero.
module uart_frame_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store one payload byte per write strobe
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < DEPTH_A)) begin
      r_mem[i_waddr[IW-1:0]] <= i_wdata;
    end
  end

  // Combinational read so the next byte is ready in the same cycle
  always_comb begin
    o_rdata = '0;
    if (i_raddr < DEPTH_A) begin
      o_rdata = r_mem[i_raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC, LEN, payload, CHK. Payload is held until the XOR
// checksum matches, then streamed out on a valid/ready interface.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 104160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] ONE       = LW'(1);

  parser_state_e r_state, w_state_nxt;

  logic [LW-1:0] r_len, w_len_nxt;
  logic [LW-1:0] r_wr_idx, w_wr_nxt;
  logic [LW-1:0] r_rd_idx, w_rd_nxt;
  logic [7:0]    r_chk, w_chk_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]    r_m_data, w_data_nxt;
  logic          r_m_valid, w_valid_nxt;
  logic          r_m_last, w_last_nxt;
  logic          r_frame_ok, w_ok_nxt;
  logic          r_frame_err, w_err_nxt;
  logic [1:0]    r_err_code, w_code_nxt;
  logic          r_overrun, w_ovr_nxt;

  logic          w_we;
  logic [LW-1:0] w_raddr;
  logic [7:0]    w_rdata;

  uart_frame_buf #(
    .DATA_W (8),
    .DEPTH  (MAX_LEN),
    .AW     (LW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_idx),
    .i_wdata (rx_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_HUNT;
    else     r_state <= w_state_nxt;
  end

  // Next-state, checksum, timeout and stream output decisions
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wr_nxt    = r_wr_idx;
    w_rd_nxt    = r_rd_idx;
    w_chk_nxt   = r_chk;
    w_tmo_nxt   = '0;
    w_data_nxt  = r_m_data;
    w_valid_nxt = r_m_valid;
    w_last_nxt  = r_m_last;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_err_code;
    w_ovr_nxt   = 1'b0;
    w_we        = 1'b0;
    // While checking, prefetch byte 0; while draining, prefetch the next one.
    w_raddr     = (r_state == ST_CHK) ? '0 : r_rd_idx + ONE;

    case (r_state)
      ST_HUNT: begin
        if (rx_strobe && (rx_data == SYNC_BYTE)) begin
          w_state_nxt = ST_LEN;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CHK: begin
        if (!rx_strobe) begin
          // A strobe arriving on the expiry cycle takes priority over the timeout.
          if (r_tmo == TMO_LAST) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TIMEOUT;
            w_state_nxt = ST_HUNT;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end else if (r_state == ST_LEN) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_LEN;
            w_state_nxt = ST_HUNT;
          end else begin
            w_len_nxt   = rx_data[LW-1:0];
            w_chk_nxt   = rx_data;
            w_wr_nxt    = '0;
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (r_state == ST_PAYLOAD) begin
          w_we      = 1'b1;
          w_chk_nxt = r_chk ^ rx_data;
          if (r_wr_idx == r_len - ONE) w_state_nxt = ST_CHK;
          else                         w_wr_nxt    = r_wr_idx + ONE;
        end else begin
          if (rx_data == r_chk) begin
            w_rd_nxt    = '0;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_rdata;
            w_last_nxt  = (r_len == ONE);
            w_ok_nxt    = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_CHK;
            w_state_nxt = ST_HUNT;
          end
        end
      end

      ST_DRAIN: begin
        // Bytes arriving while the buffer is streaming out are lost, SYNC included.
        w_ovr_nxt = rx_strobe;
        if (r_m_valid && m_ready) begin
          if (r_m_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = ST_HUNT;
          end else begin
            w_rd_nxt   = r_rd_idx + ONE;
            w_data_nxt = w_rdata;
            w_last_nxt = ((r_rd_idx + ONE) == (r_len - ONE));
          end
        end
      end

      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Counters, checksum and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_chk       <= '0;
      r_tmo       <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_overrun   <= 1'b0;
    end else begin
      r_len       <= w_len_nxt;
      r_wr_idx    <= w_wr_nxt;
      r_rd_idx    <= w_rd_nxt;
      r_chk       <= w_chk_nxt;
      r_tmo       <= w_tmo_nxt;
      r_m_data    <= w_data_nxt;
      r_m_valid   <= w_valid_nxt;
      r_m_last    <= w_last_nxt;
      r_frame_ok  <= w_ok_nxt;
      r_frame_err <= w_err_nxt;
      r_err_code  <= w_code_nxt;
      r_overrun   <= w_ovr_nxt;
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: scenario tasks drive byte streams, push the
// expected payload into a queue and compare it with captured handshakes.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  uart_frame_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int   n_ok = 0, n_err = 0, n_ovr = 0, n_both = 0;
  int   n_valid = 0, hold_viol = 0, n_77 = 0, err_cyc = 0;
  bit   prev_hold = 0;
  logic [7:0] hold_d;
  logic       hold_l;

  // Observe the stream on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (prev_hold && (!m_valid || m_data !== hold_d || m_last !== hold_l))
        hold_viol++;
      if (m_valid) n_valid++;
      if (m_valid && m_data == 8'h77) n_77++;
      if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
      if (frame_ok) n_ok++;
      if (frame_err) begin n_err++; err_cyc = cyc; end
      if (overrun) n_ovr++;
      if (frame_ok && frame_err) n_both++;
      prev_hold = m_valid && !m_ready;
      hold_d    = m_data;
      hold_l    = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(posedge clk); #1;
    rx_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_obs(input int n, output bit to);
    int k = 0;
    while (obs_q.size() < n && k < 200) begin @(posedge clk); #1; k++; end
    to = (obs_q.size() < n);
    idle(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    n_cmp++;
    if ({m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun} !== 15'd0) begin
      n_mis++;
      $display("FAIL reset_outputs got %h %b%b%b%b %0d %b want all zero",
               m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    int ok0 = n_ok, err0 = n_err;
    bit to;
    m_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_obs(3, to);
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL good_byte got %h want %h", g, e); end
    end
    n_cmp++;
    if (n_ok - ok0 != 1) begin n_mis++; $display("FAIL good_frame_ok got %0d want 1", n_ok - ok0); end
    n_cmp++;
    if (n_err != err0 || err_code !== 2'd0) begin
      n_mis++; $display("FAIL good_no_err got %0d/%0d want 0/0", n_err - err0, err_code);
    end
  endtask

  task automatic test_garbage;
    int ok0 = n_ok, err0 = n_err;
    bit to;
    exp_q.push_back({1'b1, 8'h42});
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    wait_obs(1, to);
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL garbage_byte got %h want %h", g, e); end
    end
    n_cmp++;
    if (n_err != err0 || n_ok - ok0 != 1) begin
      n_mis++; $display("FAIL garbage_pulses got err=%0d ok=%0d want err=0 ok=1", n_err - err0, n_ok - ok0);
    end
  endtask

  task automatic test_bad_frames;
    int err0 = n_err, v0 = n_valid;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    idle(3);
    n_cmp++;
    if (n_err - err0 != 1 || err_code !== 2'd2) begin
      n_mis++; $display("FAIL bad_chk got err=%0d code=%0d want err=1 code=2", n_err - err0, err_code);
    end
    send(8'hA5); send(8'h00);
    idle(3);
    n_cmp++;
    if (n_err - err0 != 2 || err_code !== 2'd1) begin
      n_mis++; $display("FAIL len_zero got err=%0d code=%0d want err=2 code=1", n_err - err0, err_code);
    end
    send(8'hA5); send(8'h11);
    idle(3);
    n_cmp++;
    if (n_err - err0 != 3 || err_code !== 2'd1) begin
      n_mis++; $display("FAIL len_big got err=%0d code=%0d want err=3 code=1", n_err - err0, err_code);
    end
    n_cmp++;
    if (n_valid != v0 || obs_q.size() != 0) begin
      n_mis++; $display("FAIL bad_no_valid got %0d valid cycles want 0", n_valid - v0);
    end
  endtask

  task automatic test_timeout;
    int err0 = n_err, ok0 = n_ok, c0, k;
    bit to;
    send(8'hA5); send(8'h02); send(8'h10);
    c0 = cyc;
    k = 0;
    while (n_err == err0 && k < 3 * TMO) begin @(posedge clk); #1; k++; end
    idle(1);
    n_cmp++;
    if (n_err == err0 || err_cyc - c0 != TMO) begin
      n_mis++; $display("FAIL timeout_delay got %0d cycles want %0d", err_cyc - c0, TMO);
    end
    n_cmp++;
    if (err_code !== 2'd3) begin n_mis++; $display("FAIL timeout_code got %0d want 3", err_code); end
    exp_q.push_back({1'b1, 8'h55});
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54);
    wait_obs(1, to);
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL after_timeout_byte got %h want %h", g, e); end
    end
    n_cmp++;
    if (n_ok - ok0 != 1 || err_code !== 2'd3) begin
      n_mis++; $display("FAIL after_timeout_ok got ok=%0d code=%0d want ok=1 code=3", n_ok - ok0, err_code);
    end
  endtask

  task automatic test_backpressure;
    int ovr0 = n_ovr, v77 = n_77;
    bit to;
    m_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b0, 8'hB2});
    exp_q.push_back({1'b1, 8'hC3});
    send(8'hA5); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD3);
    send(8'h77);
    idle(4);
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1 || m_last !== 1'b0) begin
      n_mis++; $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=a1 l=0", m_valid, m_data, m_last);
    end
    m_ready = 1'b1;
    wait_obs(3, to);
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL bp_byte got %h want %h", g, e); end
    end
    n_cmp++;
    if (n_ovr - ovr0 != 1) begin n_mis++; $display("FAIL overrun_pulse got %0d want 1", n_ovr - ovr0); end
    n_cmp++;
    if (hold_viol != 0 || n_77 != v77) begin
      n_mis++; $display("FAIL stall_stable got viol=%0d saw77=%0d want 0/0", hold_viol, n_77 - v77);
    end
  endtask

  task automatic test_max_len;
    logic [7:0] b;
    bit to;
    send(8'hA5); send(8'h10);
    for (int i = 0; i < MAX_LEN; i++) begin
      b = 8'(i * 7 + 3);
      exp_q.push_back({(i == MAX_LEN - 1), b});
      send(b);
    end
    // XOR of 0x10 and (7i+3) for i = 0..15
    b = 8'h10;
    for (int i = 0; i < MAX_LEN; i++) b = b ^ 8'(i * 7 + 3);
    send(b);
    wait_obs(MAX_LEN, to);
    n_cmp++;
    if (to) begin n_mis++; $display("FAIL maxlen_count got %0d want %0d", obs_q.size(), MAX_LEN); end
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL maxlen_byte got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_abort;
    int err0 = n_err;
    bit to;
    m_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
    rst = 1'b1; #1;
    n_cmp++;
    if ({m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun} !== 15'd0) begin
      n_mis++; $display("FAIL rst_payload got v=%b code=%0d want all zero", m_valid, err_code);
    end
    @(posedge clk); #1; rst = 1'b0;
    m_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    idle(1);
    n_cmp++;
    if (m_valid !== 1'b1) begin n_mis++; $display("FAIL drain_before_rst got v=%b want 1", m_valid); end
    rst = 1'b1; #1;
    n_cmp++;
    if ({m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun} !== 15'd0) begin
      n_mis++; $display("FAIL rst_drain got v=%b d=%h l=%b want all zero", m_valid, m_data, m_last);
    end
    @(posedge clk); #1; rst = 1'b0;
    m_ready = 1'b1;
    obs_q.delete();
    err0 = n_err;
    exp_q.push_back({1'b1, 8'h42});
    send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    wait_obs(1, to);
    while (exp_q.size() > 0) begin
      logic [8:0] e = exp_q.pop_front();
      logic [8:0] g = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h0;
      n_cmp++;
      if (g !== e) begin n_mis++; $display("FAIL post_rst_byte got %h want %h", g, e); end
    end
    n_cmp++;
    if (n_err != err0 || n_both != 0) begin
      n_mis++; $display("FAIL post_rst_pulses got err=%0d both=%0d want 0/0", n_err - err0, n_both);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_garbage();
    test_bad_frames();
    test_timeout();
    test_backpressure();
    test_max_len();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
